// File: rtl/sequence_generator_pkg.sv
// Shared types and constants for the serial sequence generator.
package seq_gen_pkg;

  // FSM encoding is fixed so external checkers can decode the debug port.
  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_e;

  // Largest supported pattern length.
  localparam int PAT_W_MAX = 32;

endpackage

// File: rtl/sequence_generator_if.sv
// Control/stream bundle between a stimulus source and sequence_generator.
//
// Handshake: a transmission request is taken when start=1 on a rising edge
// while busy=0; pattern and reps are captured on that same edge. A serial bit
// is transferred on every rising edge where out_valid=1 (out_valid is already
// low whenever hold=1, so hold is the only backpressure). done pulses for one
// cycle after the last bit; busy stays high through that cycle.
interface sequence_generator_if #(
  parameter int PAT_W = 8,
  parameter int REP_W = 4
);
  logic             start;
  logic [PAT_W-1:0] pattern;
  logic [REP_W-1:0] reps;
  logic             hold;
  logic             out_bit;
  logic             out_valid;
  logic             busy;
  logic             done;

  modport master (
    output start, pattern, reps, hold,
    input  out_bit, out_valid, busy, done
  );

  modport slave (
    input  start, pattern, reps, hold,
    output out_bit, out_valid, busy, done
  );
endinterface

// File: rtl/sequence_generator_pattern_shift_reg.sv
// Load/shift register holding the bits still to be sent; MSB is the current bit.
module pattern_shift_reg
  import seq_gen_pkg::*;
#(
  parameter int PAT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             shift,
  input  logic [PAT_W-1:0] data,
  output logic             msb
);

  logic [PAT_W-1:0] sh_q;

  // Load takes priority over shift; zeros fill in from the LSB side.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sh_q <= '0;
    end else if (load) begin
      sh_q <= data;
    end else if (shift) begin
      sh_q <= {sh_q[PAT_W-2:0], 1'b0};
    end
  end

  assign msb = sh_q[PAT_W-1];

endmodule

// File: rtl/sequence_generator.sv
// Serial pattern transmitter: sends a latched pattern MSB-first, reps times,
// one bit per clock, stalled by hold.
module sequence_generator
  import seq_gen_pkg::*;
#(
  parameter int PAT_W = 8,
  parameter int REP_W = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  sequence_generator_if.slave   bus,
  output state_e                fsm_state
);

  localparam int              IDX_W    = $clog2(PAT_W);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(PAT_W - 1);

  state_e           state_q;
  state_e           state_d;
  logic [PAT_W-1:0] pat_q;
  logic [REP_W-1:0] rep_q;
  logic [IDX_W-1:0] idx_q;

  logic             accept;
  logic             step;
  logic             last_bit;
  logic             more_reps;
  logic             sh_load;
  logic             sh_shift;
  logic [PAT_W-1:0] sh_data;
  logic             msb;

  // A bit is consumed only in SHIFT on an edge without hold.
  assign accept    = (state_q == IDLE) && bus.start;
  assign step      = (state_q == SHIFT) && !bus.hold;
  assign last_bit  = (idx_q == '0);
  assign more_reps = (rep_q > REP_W'(1));

  // Reload the shifter on acceptance and at each repetition boundary so
  // repetitions follow each other with no gap.
  assign sh_load  = accept || (step && last_bit && more_reps);
  assign sh_shift = step && !last_bit;
  assign sh_data  = accept ? bus.pattern : pat_q;

  pattern_shift_reg #(
    .PAT_W (PAT_W)
  ) u_shift (
    .clk   (clk),
    .reset (reset),
    .load  (sh_load),
    .shift (sh_shift),
    .data  (sh_data),
    .msb   (msb)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = (bus.reps != '0) ? SHIFT : DONE;
        end
      end
      SHIFT: begin
        if (step && last_bit && !more_reps) begin
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs; only out_valid looks at hold combinationally.
  always_comb begin
    bus.out_bit   = 1'b0;
    bus.out_valid = 1'b0;
    bus.busy      = 1'b0;
    bus.done      = 1'b0;
    case (state_q)
      SHIFT: begin
        bus.out_bit   = msb;
        bus.out_valid = !bus.hold;
        bus.busy      = 1'b1;
      end
      DONE: begin
        bus.busy = 1'b1;
        bus.done = 1'b1;
      end
      default: begin
        bus.out_bit = 1'b0;
      end
    endcase
  end

  // Pattern copy, bit index and repetition counter; none of them wraps.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pat_q <= '0;
      rep_q <= '0;
      idx_q <= '0;
    end else if (accept) begin
      pat_q <= bus.pattern;
      rep_q <= bus.reps;
      idx_q <= IDX_LAST;
    end else if (step) begin
      if (!last_bit) begin
        idx_q <= idx_q - IDX_W'(1);
      end else if (more_reps) begin
        idx_q <= IDX_LAST;
        rep_q <= rep_q - REP_W'(1);
      end
    end
  end

  assign fsm_state = state_q;

endmodule
